pipe_ctl_reg: RTL and testbench

//  Parametrised pipeline stage register for control bundles. Generalises the fixed per-phase control latches.

---
 rtl/pipe_ctl_pkg.sv | 27 ++
 rtl/pipe_ctl_skid.sv | 33 +++
 rtl/pipe_ctl_reg.sv | 137 +++++++++++++
 tb/tb_pipe_ctl_reg.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/pipe_ctl_pkg.sv
// Shared types and constants for the pipeline control-bundle stage registers.
// The control bundle layout is common to every stage instance (IF/ID, ID/EX, EX/MEM, ...).
package pipe_ctl_pkg;

    // Control bundle carried between pipeline phases; MSB first as listed.
    typedef struct packed {
        logic       alu_src1;
        logic       alu_src2;
        logic       alu_or_shifter;
        logic       as_bc;
        logic       mem_read;
        logic [2:0] ra;
        logic [2:0] rb;
        logic [3:0] opcode;
    } ctrl_bundle_t;

    localparam int unsigned CTRL_W = 15;

    // Bubble encoding: all control bits low, opcode 4'b0000.
    localparam ctrl_bundle_t CTRL_NOP = '0;

    // A stall cycle: a held bundle that downstream refuses.
    function automatic logic is_stall(input logic valid, input logic ready);
        return valid && !ready;
    endfunction

endpackage

// File: rtl/pipe_ctl_skid.sv
// One-entry skid buffer: a data register plus a valid flag.
// Clear has priority over load so a flush can never leave a stale entry behind.
module pipe_ctl_skid #(
    parameter int unsigned     W       = 15,
    parameter logic [W-1:0]    NOP_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    // Capture an overflow bundle; drop it on drain, flush or reset.
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            valid_q <= 1'b0;
            data_q  <= NOP_VAL;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_ctl_reg.sv
// Pipeline stage register for control bundles with valid/ready handshake, stall back-pressure,
// synchronous flush (NOP bubble insertion) and a saturating stall counter.
// Build option: define PIPE_CTL_SKID_EN to add a one-entry skid buffer and make in_ready a pure
// register output (no out_ready -> in_ready combinational path). Default: single register.
module pipe_ctl_reg
    import pipe_ctl_pkg::*;
#(
    parameter int unsigned  W       = CTRL_W,
    parameter logic [W-1:0] NOP_VAL = '0,
    parameter int unsigned  CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [CNT_W-1:0] stall_cnt
);

    logic             valid_q, valid_d;
    logic [W-1:0]     data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_xfer;
    logic             out_xfer;
    logic             stall;

    assign out_xfer = valid_q && out_ready;
    assign stall    = is_stall(valid_q, out_ready);

    // Stall counter: saturates at all-ones, only reset clears it (flush does not).
    always_comb begin
        cnt_d = cnt_q;
        if (stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

`ifdef PIPE_CTL_SKID_EN

    logic         skid_valid;
    logic [W-1:0] skid_data;
    logic         skid_load;
    logic         skid_clear;

    // in_ready depends only on the skid flop, so upstream timing is decoupled from out_ready.
    // While the skid is full nothing is accepted, even during a flush.
    assign in_ready = !skid_valid;
    assign in_xfer  = in_valid && !skid_valid;

    // Main-register next state; overflow goes to the skid, which drains first to keep order.
    always_comb begin
        valid_d    = valid_q;
        data_d     = data_q;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        if (flush) begin
            valid_d    = 1'b0;
            data_d     = NOP_VAL;
            skid_clear = 1'b1;
        end else if (skid_valid) begin
            if (out_xfer) begin
                valid_d    = 1'b1;
                data_d     = skid_data;
                skid_clear = 1'b1;
            end
        end else if (!valid_q || out_ready) begin
            if (in_xfer) begin
                valid_d = 1'b1;
                data_d  = in_data;
            end else if (out_xfer) begin
                valid_d = 1'b0;
                data_d  = NOP_VAL;
            end
        end else if (in_xfer) begin
            skid_load = 1'b1;
        end
    end

    pipe_ctl_skid #(
        .W       (W),
        .NOP_VAL (NOP_VAL)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .data_i  (in_data),
        .valid_o (skid_valid),
        .data_o  (skid_data)
    );

`else

    // Flush forces ready so an incoming bundle is consumed (and discarded) that cycle.
    assign in_ready = flush || out_ready || !valid_q;
    assign in_xfer  = in_valid && in_ready;

    // Main-register next state: flush > load > bubble on out-only transfer > hold.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
            data_d  = NOP_VAL;
        end else if (in_xfer) begin
            valid_d = 1'b1;
            data_d  = in_data;
        end else if (out_xfer) begin
            valid_d = 1'b0;
            data_d  = NOP_VAL;
        end
    end

`endif

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= NOP_VAL;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_ctl_reg.sv
// Self-checking bench for pipe_ctl_reg: table-driven per-cycle vectors with expected registered
// outputs queued at drive time, plus an ordering scoreboard of accepted bundles.
// Covers both builds; skid-specific expectations are selected by PIPE_CTL_SKID_EN.
module tb_pipe_ctl_reg;

`ifdef PIPE_CTL_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [14:0]   in_data;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [14:0]   out_data;
    logic [CW-1:0] stall_cnt;

    typedef struct {
        bit          rst;
        bit          iv;
        logic [14:0] id;
        bit          ordy;
        bit          fl;
        bit          exp_ir;
        bit          exp_ov;
        logic [14:0] exp_od;
        logic [3:0]  exp_cnt;
    } vec_t;

    vec_t        exp_q[$];
    logic [14:0] data_q[$];
    vec_t        tbl[17];
    int          n_tests = 0;
    int          n_fail  = 0;

    pipe_ctl_reg #(
        .W       (15),
        .NOP_VAL (15'h0000),
        .CNT_W   (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input bit r, input bit iv, input logic [14:0] id, input bit ordy,
                                input bit fl, input bit ir, input bit ov, input logic [14:0] od,
                                input logic [3:0] c);
        vec_t v;
        v.rst = r;  v.iv = iv;  v.id = id;  v.ordy = ordy;  v.fl = fl;
        v.exp_ir = ir;  v.exp_ov = ov;  v.exp_od = od;  v.exp_cnt = c;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Called just after a posedge: drive, check mid-cycle, then check just after the next edge.
    task automatic run_vec(input vec_t v, input string tag);
        vec_t        e;
        logic [14:0] want;
        rst       = v.rst;
        in_valid  = v.iv;
        in_data   = v.id;
        out_ready = v.ordy;
        flush     = v.fl;
        exp_q.push_back(v);
        #3;
        chk($sformatf("%s.in_ready", tag), {31'b0, in_ready}, {31'b0, v.exp_ir});
        if (v.rst) begin
            data_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (data_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL %s.order: got %0h want no transfer", tag, out_data);
                end else begin
                    want = data_q.pop_front();
                    chk($sformatf("%s.order", tag), {17'b0, out_data}, {17'b0, want});
                end
            end
            if (v.fl) data_q.delete();
            else if (in_valid && in_ready) data_q.push_back(in_data);
        end
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk($sformatf("%s.out_valid", tag), {31'b0, out_valid}, {31'b0, e.exp_ov});
        chk($sformatf("%s.out_data", tag), {17'b0, out_data}, {17'b0, e.exp_od});
        chk($sformatf("%s.stall_cnt", tag), {28'b0, stall_cnt}, {28'b0, e.exp_cnt});
    endtask

    initial begin
        logic [3:0] exp_c;

        // Reset with garbage on the input, then streaming, stall, flush-in-stall, flush+out.
        tbl[0]  = mk(1, 1, 15'h7FFF, 0, 0, 1, 0, 15'h0000, 0);
        tbl[1]  = mk(1, 1, 15'h7FFF, 0, 0, 1, 0, 15'h0000, 0);
        tbl[2]  = mk(0, 1, 15'h0011, 1, 0, 1, 1, 15'h0011, 0);
        tbl[3]  = mk(0, 1, 15'h0022, 1, 0, 1, 1, 15'h0022, 0);
        tbl[4]  = mk(0, 1, 15'h0033, 1, 0, 1, 1, 15'h0033, 0);
        tbl[5]  = mk(0, 0, 15'h0000, 1, 0, 1, 0, 15'h0000, 0);
        tbl[6]  = mk(0, 1, 15'h1234, 1, 0, 1, 1, 15'h1234, 0);
        tbl[7]  = mk(0, 1, 15'h5555, 0, 0, SKID, 1, 15'h1234, 1);
        tbl[8]  = mk(0, 1, 15'h5555, 0, 0, 0, 1, 15'h1234, 2);
        tbl[9]  = mk(0, 1, 15'h5555, 0, 0, 0, 1, 15'h1234, 3);
        tbl[10] = mk(0, 1, 15'h5555, 0, 0, 0, 1, 15'h1234, 4);
        tbl[11] = mk(0, 1, 15'h5555, 0, 0, 0, 1, 15'h1234, 5);
        tbl[12] = mk(0, 1, 15'h0F0F, 0, 1, !SKID, 0, 15'h0000, 6);
        tbl[13] = mk(0, 0, 15'h0000, 0, 0, 1, 0, 15'h0000, 6);
        tbl[14] = mk(0, 1, 15'h0042, 1, 0, 1, 1, 15'h0042, 6);
        tbl[15] = mk(0, 1, 15'h0099, 1, 1, 1, 0, 15'h0000, 6);
        tbl[16] = mk(0, 0, 15'h0000, 0, 0, 1, 0, 15'h0000, 6);

        rst = 1'b1;  in_valid = 1'b0;  in_data = '0;  out_ready = 1'b0;  flush = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 17; i++) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // Counter saturation, survival across flush, clear by reset.
        run_vec(mk(1, 0, 15'h0000, 0, 0, 1, 0, 15'h0000, 0), "sat_rst");
        run_vec(mk(0, 1, 15'h00AB, 0, 0, 1, 1, 15'h00AB, 0), "sat_load");
        exp_c = 4'd0;
        for (int k = 0; k < 20; k++) begin
            exp_c = (exp_c == 4'hF) ? 4'hF : 4'(exp_c + 4'd1);
            run_vec(mk(0, 0, 15'h0000, 0, 0, SKID, 1, 15'h00AB, exp_c),
                    $sformatf("sat_stall%0d", k));
        end
        run_vec(mk(0, 0, 15'h0000, 0, 1, 1, 0, 15'h0000, 4'hF), "sat_flush");
        run_vec(mk(0, 0, 15'h0000, 0, 0, 1, 0, 15'h0000, 4'hF), "sat_hold");
        run_vec(mk(1, 0, 15'h0000, 0, 0, 1, 0, 15'h0000, 0), "sat_clr");

`ifdef PIPE_CTL_SKID_EN
        // Skid: overflow during stall, in-order drain, flush with skid full.
        run_vec(mk(0, 1, 15'h0001, 1, 0, 1, 1, 15'h0001, 0), "sk_load");
        run_vec(mk(0, 1, 15'h0002, 0, 0, 1, 1, 15'h0001, 1), "sk_push");
        run_vec(mk(0, 0, 15'h0000, 0, 0, 0, 1, 15'h0001, 2), "sk_full");
        run_vec(mk(0, 0, 15'h0000, 1, 0, 0, 1, 15'h0002, 2), "sk_drain");
        run_vec(mk(0, 0, 15'h0000, 1, 0, 1, 0, 15'h0000, 2), "sk_empty");
        run_vec(mk(0, 1, 15'h0003, 1, 0, 1, 1, 15'h0003, 2), "sk_load3");
        run_vec(mk(0, 1, 15'h0004, 0, 0, 1, 1, 15'h0003, 3), "sk_push4");
        run_vec(mk(0, 0, 15'h0000, 0, 1, 0, 0, 15'h0000, 4), "sk_flush");
        run_vec(mk(0, 0, 15'h0000, 0, 0, 1, 0, 15'h0000, 4), "sk_after");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
